// File: rtl/sprite_pkg.sv
// Shared constants and register map for the sprite animation controller.
package sprite_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int ADDR_WIDTH = 10;
    localparam int SPRITE_DIM = 32;
    localparam logic [11:0] KEY_COLOR = 12'hF0F;

    // Width of the stored part of the ctrl register (bit 12 is a write-only strobe)
    localparam int CTRL_W = 12;

    typedef enum logic [1:0] {
        REG_OX   = 2'd0,
        REG_OY   = 2'd1,
        REG_CTRL = 2'd2,
        REG_PIX  = 2'd3
    } reg_addr_e;

endpackage

// File: rtl/sprite_anim_counter.sv
// Frame/tick counter: steps the displayed animation frame on video-frame
// boundaries only, so the read frame never changes in the middle of a frame.
module sprite_anim_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       anim_en,
    input  logic [5:0] period,
    input  logic [1:0] last_frame,
    output logic [1:0] frame
);

    logic [5:0] tick_cnt;

    // Count frame ticks; every (period+1)-th tick advances the frame, wrapping after last_frame.
    // ctrl fields arrive from registers, so a ctrl write landing on a tick is seen one cycle late.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            frame    <= '0;
        end else if (!anim_en) begin
            tick_cnt <= '0;
        end else if (frame_tick) begin
            if (tick_cnt == period) begin
                tick_cnt <= '0;
                frame    <= (frame >= last_frame) ? 2'd0 : frame + 2'd1;
            end else begin
                tick_cnt <= tick_cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Sprite animation controller: bus register file, sprite RAM write port,
// frame animation and a 2-stage pixel pipeline with colour-key transparency.
module sprite_anim_ctrl #(
    parameter int DATA_WIDTH = sprite_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = sprite_pkg::ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR = sprite_pkg::KEY_COLOR
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cs,
    input  logic                  write,
    input  logic [1:0]            addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    input  logic [10:0]           x,
    input  logic [10:0]           y,
    input  logic                  frame_tick,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [1:0]            ram_wr_frame,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    output logic [1:0]            ram_frame_sel,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  sprite_on,
    output logic [DATA_WIDTH-1:0] sprite_rgb
);

    import sprite_pkg::*;

    logic                  bus_wr;
    logic [10:0]           origin_x;
    logic [10:0]           origin_y;
    logic [CTRL_W-1:0]     ctrl_q;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [1:0]            frame;
    logic [10:0]           xr;
    logic [10:0]           yr;
    logic                  in_box;
    logic                  in_d1;
    logic                  in_d2;
    logic [DATA_WIDTH-1:0] ram_dout_q;
    logic                  unused_wr_bits;

    assign bus_wr = cs && write;
    assign unused_wr_bits = ^wr_data[31:13];

    // Bus register writes and the one-cycle RAM write pulse that follows a pixel write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            origin_x     <= '0;
            origin_y     <= '0;
            ctrl_q       <= '0;
            wptr         <= '0;
            ram_we       <= 1'b0;
            ram_addr_w   <= '0;
            ram_din      <= '0;
            ram_wr_frame <= '0;
        end else begin
            ram_we <= 1'b0;
            if (bus_wr) begin
                case (reg_addr_e'(addr))
                    REG_OX:   origin_x <= wr_data[10:0];
                    REG_OY:   origin_y <= wr_data[10:0];
                    REG_CTRL: begin
                        ctrl_q <= wr_data[CTRL_W-1:0];
                        if (wr_data[12]) begin
                            wptr <= '0;
                        end
                    end
                    REG_PIX: begin
                        ram_we       <= 1'b1;
                        ram_addr_w   <= wptr;
                        ram_din      <= wr_data[DATA_WIDTH-1:0];
                        ram_wr_frame <= ctrl_q[11:10];
                        wptr         <= wptr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register readback; addr 3 reports the write pointer and the displayed frame.
    always_comb begin
        rd_data = '0;
        case (reg_addr_e'(addr))
            REG_OX:   rd_data = 32'(origin_x);
            REG_OY:   rd_data = 32'(origin_y);
            REG_CTRL: rd_data = 32'(ctrl_q);
            REG_PIX:  rd_data = (32'(wptr) << 16) | 32'(frame);
            default:  rd_data = '0;
        endcase
    end

    sprite_anim_counter u_anim (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .anim_en    (ctrl_q[1]),
        .period     (ctrl_q[7:2]),
        .last_frame (ctrl_q[9:8]),
        .frame      (frame)
    );

    assign ram_frame_sel = frame;

    // Sprite-relative coordinates; the subtraction wraps so pixels left/above the origin fall outside.
    assign xr     = x - origin_x;
    assign yr     = y - origin_y;
    assign in_box = ctrl_q[0] && (xr < 11'(SPRITE_DIM)) && (yr < 11'(SPRITE_DIM));

    // Pixel pipeline: stage 1 launches the RAM read address, stage 2 captures the returned colour.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_addr_r <= '0;
            in_d1      <= 1'b0;
            in_d2      <= 1'b0;
            ram_dout_q <= '0;
        end else begin
            ram_addr_r <= ADDR_WIDTH'({yr[4:0], xr[4:0]});
            in_d1      <= in_box;
            in_d2      <= in_d1;
            ram_dout_q <= ram_dout;
        end
    end

    // Key-coloured pixels are transparent; the colour output is blanked whenever the sprite is off.
    always_comb begin
        sprite_on  = in_d2 && (ram_dout_q != KEY_COLOR);
        sprite_rgb = sprite_on ? ram_dout_q : '0;
    end

endmodule
